// File: rtl/vec_vrf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_vrf_pkg
//  Description : Shared constants, types and helpers for the banked VRF.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_vrf_pkg;

    // Default configuration; the top module derives its own widths from its parameters.
    localparam int DEF_VLEN  = 512;
    localparam int DEF_NREG  = 32;
    localparam int DEF_NBANK = 4;

    localparam int VLENB   = DEF_VLEN / 8;
    localparam int REG_AW  = $clog2(DEF_NREG);
    localparam int BANK_AW = $clog2(DEF_NBANK);

    typedef logic [DEF_VLEN-1:0] vreg_t;
    typedef logic [VLENB-1:0]    vbe_t;

    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned nbank);
        return addr % nbank;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_vrf_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : vec_vrf_rr_arb
//  Description : Per-bank round-robin read arbiter with same-address broadcast.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_vrf_rr_arb #(
    parameter int RPORT = 4,
    parameter int AW    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en_i,
    input  logic [RPORT-1:0]          req_i,
    input  logic [RPORT-1:0][AW-1:0]  addr_i,
    output logic [RPORT-1:0]          gnt_o
);

    localparam int PW = (RPORT > 1) ? $clog2(RPORT) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          w_found;
    int unsigned   w_idx;
    int unsigned   w_win;
    int unsigned   w_low;
    logic [AW-1:0] w_win_addr;

    always_comb begin
        w_found = 1'b0;
        w_idx   = 0;
        w_win   = 0;
        for (int k = 0; k < RPORT; k++) begin
            w_idx = (32'(ptr_q) + 32'(k)) % RPORT;
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_win_addr = addr_i[w_win];

        // Every requester sharing the winner's address rides along on the same bank read.
        gnt_o = '0;
        for (int i = 0; i < RPORT; i++) begin
            gnt_o[i] = w_found && req_i[i] && (addr_i[i] == w_win_addr);
        end

        w_low = 0;
        for (int i = RPORT - 1; i >= 0; i--) begin
            if (gnt_o[i]) begin
                w_low = 32'(i);
            end
        end

        ptr_d = ptr_q;
        if (clk_en_i && (|gnt_o)) begin
            ptr_d = (w_low == 32'(RPORT - 1)) ? '0 : PW'(w_low + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vec_vrf_banked.sv
`default_nettype none
// ============================================================================
//  Module      : vec_vrf_banked
//  Description : Banked vector register file with byte writes, per-bank read
//                arbitration and same-cycle write-to-read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_vrf_banked
    import vec_vrf_pkg::*;
#(
    parameter int WPORT = 4,
    parameter int RPORT = 4,
    parameter int VLEN  = DEF_VLEN,
    parameter int NREG  = DEF_NREG,
    parameter int NBANK = DEF_NBANK
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clk_en_i,
    input  logic [WPORT-1:0]                     wr_en_i,
    input  logic [WPORT-1:0][VLEN/8-1:0]         wr_be_i,
    input  logic [WPORT-1:0][$clog2(NREG)-1:0]   wr_addr_i,
    input  logic [WPORT-1:0][VLEN-1:0]           wr_data_i,
    input  logic [RPORT-1:0]                     rd_valid_i,
    input  logic [RPORT-1:0][$clog2(NREG)-1:0]   rd_addr_i,
    output logic [RPORT-1:0]                     rd_ready_o,
    output logic [RPORT-1:0]                     rd_rvalid_o,
    output logic [RPORT-1:0][VLEN-1:0]           rd_data_o
);

    localparam int NBYTE  = VLEN / 8;
    localparam int ADDR_W = $clog2(NREG);
    localparam int NROW   = NREG / NBANK;

    logic [VLEN-1:0]               bank_q [NBANK][NROW];
    logic [VLEN-1:0]               bank_d [NBANK][NROW];
    logic [RPORT-1:0]              rd_rvalid_q;
    logic [RPORT-1:0][VLEN-1:0]    rd_data_q;
    logic [RPORT-1:0][VLEN-1:0]    rd_data_d;

    logic [NBANK-1:0][RPORT-1:0]   w_bank_req;
    logic [NBANK-1:0][RPORT-1:0]   w_bank_gnt;
    logic [RPORT-1:0]              w_granted;
    logic [RPORT-1:0]              w_rd_ready;
    logic                          w_upd;

    function automatic int unsigned row_of(input logic [ADDR_W-1:0] a);
        return 32'(a) / NBANK;
    endfunction

    assign w_upd = clk_en_i & ~rst;

    always_comb begin
        w_bank_req = '0;
        for (int i = 0; i < RPORT; i++) begin
            w_bank_req[bank_of(32'(rd_addr_i[i]), NBANK)][i] = rd_valid_i[i];
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        vec_vrf_rr_arb #(
            .RPORT (RPORT),
            .AW    (ADDR_W)
        ) u_arb (
            .clk      (clk),
            .rst      (rst),
            .clk_en_i (clk_en_i),
            .req_i    (w_bank_req[b]),
            .addr_i   (rd_addr_i),
            .gnt_o    (w_bank_gnt[b])
        );
    end

    always_comb begin
        w_granted = '0;
        for (int b = 0; b < NBANK; b++) begin
            w_granted = w_granted | w_bank_gnt[b];
        end
        w_rd_ready = rd_valid_i & w_granted & {RPORT{w_upd}};
    end

    // Ports applied in ascending order so the highest index wins each byte.
    always_comb begin
        bank_d = bank_q;
        for (int p = 0; p < WPORT; p++) begin
            for (int k = 0; k < NBYTE; k++) begin
                if (wr_en_i[p] && wr_be_i[p][k]) begin
                    bank_d[bank_of(32'(wr_addr_i[p]), NBANK)][row_of(wr_addr_i[p])][8*k +: 8] =
                        wr_data_i[p][8*k +: 8];
                end
            end
        end
    end

    // Reading the post-write image gives full forwarding from every write port.
    always_comb begin
        rd_data_d = rd_data_q;
        for (int i = 0; i < RPORT; i++) begin
            if (w_rd_ready[i]) begin
                rd_data_d[i] = bank_d[bank_of(32'(rd_addr_i[i]), NBANK)][row_of(rd_addr_i[i])];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q      <= '{default: '0};
            rd_rvalid_q <= '0;
            rd_data_q   <= '0;
        end else if (clk_en_i) begin
            bank_q      <= bank_d;
            rd_rvalid_q <= w_rd_ready;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_ready_o  = w_rd_ready;
    assign rd_rvalid_o = rd_rvalid_q;
    assign rd_data_o   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_vrf_banked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_vrf_banked
//  Description : Self-checking bench: directed vector table plus random traffic
//                against a register-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_vrf_banked;
    import vec_vrf_pkg::*;

    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 ce;
    logic [3:0]           wen;
    logic [3:0][63:0]     wbe;
    logic [3:0][4:0]      waddr;
    logic [3:0][511:0]    wdata;
    logic [3:0]           rv;
    logic [3:0][4:0]      raddr;
    logic [3:0]           rd_ready;
    logic [3:0]           rd_rvalid;
    logic [3:0][511:0]    rd_data;

    vec_vrf_banked dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en_i    (ce),
        .wr_en_i     (wen),
        .wr_be_i     (wbe),
        .wr_addr_i   (waddr),
        .wr_data_i   (wdata),
        .rd_valid_i  (rv),
        .rd_addr_i   (raddr),
        .rd_ready_o  (rd_ready),
        .rd_rvalid_o (rd_rvalid),
        .rd_data_o   (rd_data)
    );

    int total = 0;
    int bad   = 0;
    logic [3:0] got_ready;

    // Reference model state
    vreg_t      m_mem [32];
    int         m_ptr [4];
    logic [3:0] m_rvalid;
    vreg_t      m_rdata [4];

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] g;
        int win;
        int p;
        g = '0;
        if (rst || !ce) return g;
        for (int b = 0; b < 4; b++) begin
            win = -1;
            for (int k = 0; k < 4; k++) begin
                p = (m_ptr[b] + k) % 4;
                if (win < 0 && rv[p] && (int'(raddr[p]) % 4 == b)) win = p;
            end
            if (win >= 0) begin
                for (int q = 0; q < 4; q++) begin
                    if (rv[q] && raddr[q] == raddr[win]) g[q] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    task automatic model_step(input logic [3:0] g);
        int low;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_mem[r] = '0;
            for (int b = 0; b < 4; b++) m_ptr[b] = 0;
            m_rvalid = '0;
            for (int p = 0; p < 4; p++) m_rdata[p] = '0;
        end else if (ce) begin
            for (int p = 0; p < 4; p++)
                for (int k = 0; k < 64; k++)
                    if (wen[p] && wbe[p][k]) m_mem[waddr[p]][8*k +: 8] = wdata[p][8*k +: 8];
            for (int p = 0; p < 4; p++)
                if (g[p]) m_rdata[p] = m_mem[raddr[p]];
            m_rvalid = g;
            for (int b = 0; b < 4; b++) begin
                low = -1;
                for (int p = 3; p >= 0; p--)
                    if (g[p] && (int'(raddr[p]) % 4 == b)) low = p;
                if (low >= 0) m_ptr[b] = (low + 1) % 4;
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        logic [3:0] er;
        #1;
        er = model_ready();
        got_ready = rd_ready;
        chk("ready", 512'(got_ready), 512'(er));
        model_step(er);
        @(posedge clk);
        #1;
        chk("rvalid", 512'(rd_rvalid), 512'(m_rvalid));
        for (int p = 0; p < 4; p++) chk($sformatf("data%0d", p), rd_data[p], m_rdata[p]);
        @(negedge clk);
    endtask

    typedef struct {
        bit              rst;
        bit              ce;
        bit [3:0]        wen;
        bit [3:0][4:0]   waddr;
        bit [3:0][7:0]   wbyte;
        bit [3:0][63:0]  wbe;
        bit [3:0]        rv;
        bit [3:0][4:0]   raddr;
        bit [3:0]        er;
        bit [3:0]        ev;
        bit [3:0]        cd;
        bit [3:0][31:0]  lo;
        bit [3:0][7:0]   hi;
    } vec_t;

    vec_t       r;
    vec_t       tbl [$];
    logic [3:0] pend;

    initial begin
        rst = 1'b1; ce = 1'b1; wen = '0; wbe = '0; waddr = '0; wdata = '0; rv = '0; raddr = '0;
        for (int b = 0; b < 4; b++) m_ptr[b] = 0;
        m_rvalid = '0;

        // Reset, then read v5
        r = '{default: '0}; r.rst = 1; r.ce = 1; r.cd = 4'hF; tbl.push_back(r);
        r = '{default: '0}; r.ce = 1; r.rv = 4'b0001; r.raddr[0] = 5;
        r.er = 4'b0001; r.ev = 4'b0001; r.cd = 4'b0001; tbl.push_back(r);
        // Byte-enable write and forward
        r = '{default: '0}; r.ce = 1; r.wen = 4'b0010; r.waddr[1] = 3; r.wbyte[1] = 8'hAA; r.wbe[1] = ALL;
        r.cd = 4'b0001; tbl.push_back(r);
        r = '{default: '0}; r.ce = 1; r.wen = 4'b0100; r.waddr[2] = 3; r.wbyte[2] = 8'h55; r.wbe[2] = 64'h1;
        r.rv = 4'b0001; r.raddr[0] = 3; r.er = 4'b0001; r.ev = 4'b0001; r.cd = 4'b0001;
        r.lo[0] = 32'hAAAA_AA55; r.hi[0] = 8'hAA; tbl.push_back(r);
        // Write-write priority
        r = '{default: '0}; r.ce = 1; r.wen = 4'b1001; r.waddr[0] = 7; r.waddr[3] = 7;
        r.wbyte[0] = 8'h11; r.wbyte[3] = 8'h33; r.wbe[0] = ALL; r.wbe[3] = ALL; tbl.push_back(r);
        r = '{default: '0}; r.ce = 1; r.rv = 4'b0010; r.raddr[1] = 7; r.er = 4'b0010; r.ev = 4'b0010;
        r.cd = 4'b0010; r.lo[1] = 32'h3333_3333; r.hi[1] = 8'h33; tbl.push_back(r);
        r = '{default: '0}; r.ce = 1; r.wen = 4'b1001; r.waddr[0] = 7; r.waddr[3] = 7;
        r.wbyte[0] = 8'h11; r.wbyte[3] = 8'h33; r.wbe[0] = ALL; r.wbe[3] = 64'h0F; tbl.push_back(r);
        r = '{default: '0}; r.ce = 1; r.rv = 4'b0100; r.raddr[2] = 7; r.er = 4'b0100; r.ev = 4'b0100;
        r.cd = 4'b0100; r.lo[2] = 32'h3333_3333; r.hi[2] = 8'h11; tbl.push_back(r);
        // Bank-0 conflict: grant order 0,1,2,3
        for (int c = 0; c < 4; c++) begin
            r = '{default: '0}; r.ce = 1; r.rv = 4'b1111;
            r.raddr[0] = 0; r.raddr[1] = 4; r.raddr[2] = 8; r.raddr[3] = 12;
            r.er = 4'(1 << c); r.ev = 4'(1 << c); r.cd = 4'(1 << c); tbl.push_back(r);
        end
        // Broadcast, no conflict, with same-cycle forward into v9
        r = '{default: '0}; r.ce = 1; r.wen = 4'b0001; r.waddr[0] = 9; r.wbyte[0] = 8'h5A; r.wbe[0] = ALL;
        r.rv = 4'b1111; r.raddr[0] = 9; r.raddr[1] = 9; r.raddr[2] = 2; r.raddr[3] = 3;
        r.er = 4'b1111; r.ev = 4'b1111; r.cd = 4'b1111;
        r.lo[0] = 32'h5A5A_5A5A; r.hi[0] = 8'h5A; r.lo[1] = 32'h5A5A_5A5A; r.hi[1] = 8'h5A;
        r.lo[3] = 32'hAAAA_AA55; r.hi[3] = 8'hAA; tbl.push_back(r);
        // v9 and v1 share bank 1: only the v9 group is served
        r = '{default: '0}; r.ce = 1; r.rv = 4'b1111;
        r.raddr[0] = 9; r.raddr[1] = 9; r.raddr[2] = 1; r.raddr[3] = 2;
        r.er = 4'b1011; r.ev = 4'b1011; r.cd = 4'b0101; r.lo[0] = 32'h5A5A_5A5A; r.hi[0] = 8'h5A;
        tbl.push_back(r);
        // clk_en low: nothing moves
        r = '{default: '0}; r.ce = 0; r.wen = 4'b0001; r.waddr[0] = 3; r.wbyte[0] = 8'hFF; r.wbe[0] = ALL;
        r.rv = 4'b0001; r.raddr[0] = 3; r.er = 4'b0000; r.ev = 4'b1011; r.cd = 4'b0001;
        r.lo[0] = 32'h5A5A_5A5A; r.hi[0] = 8'h5A; tbl.push_back(r);
        r = '{default: '0}; r.ce = 1; r.rv = 4'b0001; r.raddr[0] = 3; r.er = 4'b0001; r.ev = 4'b0001;
        r.cd = 4'b0001; r.lo[0] = 32'hAAAA_AA55; r.hi[0] = 8'hAA; tbl.push_back(r);
        // Reset right after an accepted read
        r = '{default: '0}; r.ce = 1; r.rv = 4'b0010; r.raddr[1] = 3; r.er = 4'b0010; r.ev = 4'b0010;
        r.cd = 4'b0010; r.lo[1] = 32'hAAAA_AA55; r.hi[1] = 8'hAA; tbl.push_back(r);
        r = '{default: '0}; r.rst = 1; r.ce = 1; r.rv = 4'b0001; r.raddr[0] = 3; r.cd = 4'hF;
        tbl.push_back(r);
        r = '{default: '0}; r.ce = 1; r.rv = 4'b0010; r.raddr[1] = 3; r.er = 4'b0010; r.ev = 4'b0010;
        r.cd = 4'b0010; tbl.push_back(r);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; ce = tbl[i].ce; wen = tbl[i].wen; waddr = tbl[i].waddr; wbe = tbl[i].wbe;
            for (int p = 0; p < 4; p++) wdata[p] = {64{tbl[i].wbyte[p]}};
            rv = tbl[i].rv; raddr = tbl[i].raddr;
            tick();
            chk($sformatf("tbl%0d_ready", i), 512'(got_ready), 512'(tbl[i].er));
            chk($sformatf("tbl%0d_rvalid", i), 512'(rd_rvalid), 512'(tbl[i].ev));
            for (int p = 0; p < 4; p++)
                if (tbl[i].cd[p])
                    chk($sformatf("tbl%0d_data%0d", i, p), rd_data[p], {{60{tbl[i].hi[p]}}, tbl[i].lo[p]});
        end

        // Random traffic; ungranted requests are held until served
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            ce  = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < 4; p++) begin
                wen[p]   = 1'($urandom_range(0, 1));
                waddr[p] = 5'($urandom_range(0, 11));
                wbe[p]   = ($urandom_range(0, 1) != 0) ? ALL : {$urandom(), $urandom()};
                for (int j = 0; j < 16; j++) wdata[p][32*j +: 32] = $urandom();
                if (!pend[p]) begin
                    rv[p]    = 1'($urandom_range(0, 1));
                    raddr[p] = 5'($urandom_range(0, 11));
                end
            end
            tick();
            pend = rv & ~got_ready & {4{~rst}};
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
